// File: rtl/mccpu_mem_pkg.sv
// ============================================================================
// Module   : mccpu_mem_pkg
// Brief    : Shared encodings for the multicycle CPU memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mccpu_mem_pkg;

    // Store width encodings; 2'b11 is reserved and behaves as a word store
    localparam logic [1:0] SW_WORD = 2'b00;
    localparam logic [1:0] SW_HALF = 2'b01;
    localparam logic [1:0] SW_BYTE = 2'b10;

    localparam int         STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] WAIT = 2'd1;
    localparam logic [STATE_W-1:0] RESP = 2'd2;

    localparam int WAIT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_store_merge.sv
// ============================================================================
// Module   : mem_store_merge
// Brief    : Combinational little-endian byte-lane merge of store data into a word.
// Options  : MCCPU_MEM_ALIGN_CHK_EN adds the misalign flag output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_store_merge
    import mccpu_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  store_whb,
    input  logic [1:0]  adr_lo,
    output logic [31:0] new_word
`ifdef MCCPU_MEM_ALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    logic w_misalign;

    always_comb begin
        new_word   = old_word;
        w_misalign = 1'b0;
        case (store_whb)
            SW_BYTE: begin
                case (adr_lo)
                    2'd0:    new_word[7:0]   = wdata[7:0];
                    2'd1:    new_word[15:8]  = wdata[7:0];
                    2'd2:    new_word[23:16] = wdata[7:0];
                    default: new_word[31:24] = wdata[7:0];
                endcase
            end
            SW_HALF: begin
                // adr_lo[0] does not select a lane, it only flags misalignment
                if (adr_lo[1]) new_word[31:16] = wdata[15:0];
                else           new_word[15:0]  = wdata[15:0];
                w_misalign = adr_lo[0];
            end
            default: begin
                new_word   = wdata;
                w_misalign = (adr_lo != 2'b00);
            end
        endcase
    end

`ifdef MCCPU_MEM_ALIGN_CHK_EN
    assign misalign = w_misalign;
`else
    logic w_unused_misalign;
    assign w_unused_misalign = w_misalign;
`endif

endmodule

`default_nettype wire

// File: rtl/mccpu_mem_responder.sv
// ============================================================================
// Module   : mccpu_mem_responder
// Brief    : Single-outstanding memory responder with programmable wait states
//            and sub-word stores over an internal word-organised RAM.
// Options  : MCCPU_MEM_ALIGN_CHK_EN adds the misalign output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mccpu_mem_responder
    import mccpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        MemWrite,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic [1:0]  STOREwhb,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        busy
`ifdef MCCPU_MEM_ALIGN_CHK_EN
    ,
    output logic        misalign
`endif
);

    localparam int c_depth = 2 ** ADDR_WIDTH;
    localparam logic [WAIT_CNT_W-1:0] c_wait_last =
        WAIT_CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
    logic                  w_accept;

    logic [ADDR_WIDTH-1:0] r_idx;
    logic [1:0]            r_lo;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [1:0]            r_whb;

    logic [31:0]           r_mem [0:c_depth-1];
    logic [31:0]           w_old_word;
    logic [31:0]           w_new_word;
    logic                  w_ram_we;
    logic                  w_store_ok;

    logic [31:0]           r_readdata;
    logic                  r_ready;
    logic                  r_busy;

    logic                  w_unused_adr;
    assign w_unused_adr = ^adr[31:ADDR_WIDTH+2];

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_accept       = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_accept       = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_wait_cnt == c_wait_last) begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = RESP;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            // ready and readdata are registered off RESP, so they land one edge later
            r_ready    <= (r_state == RESP);
            r_busy     <= w_accept || (r_state != IDLE);
            if (r_state == RESP) r_readdata <= w_old_word;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= adr[ADDR_WIDTH+1:2];
            r_lo    <= adr[1:0];
            r_we    <= MemWrite;
            r_wdata <= writedata;
            r_whb   <= STOREwhb;
        end
    end

    assign w_old_word = r_mem[r_idx];

`ifdef MCCPU_MEM_ALIGN_CHK_EN
    logic w_misalign;
    logic r_misalign;

    mem_store_merge u_merge (
        .old_word  (w_old_word),
        .wdata     (r_wdata),
        .store_whb (r_whb),
        .adr_lo    (r_lo),
        .new_word  (w_new_word),
        .misalign  (w_misalign)
    );

    assign w_store_ok = !w_misalign;

    always_ff @(posedge clk) begin
        if (rst) r_misalign <= 1'b0;
        else     r_misalign <= (r_state == RESP) && w_misalign;
    end

    assign misalign = r_misalign;
`else
    mem_store_merge u_merge (
        .old_word  (w_old_word),
        .wdata     (r_wdata),
        .store_whb (r_whb),
        .adr_lo    (r_lo),
        .new_word  (w_new_word)
    );

    assign w_store_ok = 1'b1;
`endif

    // Reset on the RESP edge drops the pending write
    assign w_ram_we = !rst && (r_state == RESP) && r_we && w_store_ok;

    always_ff @(posedge clk) begin
        if (w_ram_we) r_mem[r_idx] <= w_new_word;
    end

    assign readdata = r_readdata;
    assign ready    = r_ready;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mccpu_mem_responder.sv
// ============================================================================
// Module   : tb_mccpu_mem_responder
// Brief    : Self-checking bench with a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mccpu_mem_responder;
    import mccpu_mem_pkg::*;

    localparam int W_A = 1;
    localparam int W_B = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0, MemWrite = 1'b0;
    logic [31:0] adr = '0, writedata = '0;
    logic [1:0]  STOREwhb = '0;
    logic [31:0] readdata;
    logic        ready, busy;
    logic        mem_req_b = 1'b0;
    logic [31:0] readdata_b;
    logic        ready_b, busy_b;
`ifdef MCCPU_MEM_ALIGN_CHK_EN
    logic        misalign, misalign_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [0:1023];
    bit          known [0:1023];

    always #5 clk = ~clk;

    mccpu_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W_A)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .MemWrite(MemWrite), .adr(adr),
        .writedata(writedata), .STOREwhb(STOREwhb), .readdata(readdata),
        .ready(ready), .busy(busy)
`ifdef MCCPU_MEM_ALIGN_CHK_EN
        , .misalign(misalign)
`endif
    );

    mccpu_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W_B)) dut_b (
        .clk(clk), .rst(rst), .mem_req(mem_req_b), .MemWrite(1'b0), .adr(32'h0),
        .writedata(32'h0), .STOREwhb(2'b00), .readdata(readdata_b),
        .ready(ready_b), .busy(busy_b)
`ifdef MCCPU_MEM_ALIGN_CHK_EN
        , .misalign(misalign_b)
`endif
    );

    function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] whb);
        return (whb == SW_HALF && a[0]) || ((whb == SW_WORD || whb == 2'b11) && a[1:0] != 2'b00);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] whb);
        int idx;
        int sh;
        logic [31:0] mask;
        idx = int'(a[11:2]);
`ifdef MCCPU_MEM_ALIGN_CHK_EN
        if (is_misaligned(a, whb)) return;
`endif
        if (whb == SW_BYTE) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
            model[idx] = (model[idx] & ~mask) | ((wd & 32'hFF) << sh);
        end else if (whb == SW_HALF) begin
            sh = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
            model[idx] = (model[idx] & ~mask) | ((wd & 32'hFFFF) << sh);
        end else begin
            model[idx] = wd;
            known[idx] = 1'b1;
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] whb, output logic [31:0] rd, output int lat,
                        output logic mis);
        @(negedge clk);
        mem_req = 1'b1; MemWrite = we; adr = a; writedata = wd; STOREwhb = whb;
        @(posedge clk);
        #1;
        mem_req = 1'b0; MemWrite = 1'($urandom); adr = $urandom; writedata = $urandom;
        STOREwhb = 2'($urandom);
        lat = -1; rd = '0; mis = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                rd  = readdata;
`ifdef MCCPU_MEM_ALIGN_CHK_EN
                mis = misalign;
`endif
                break;
            end
        end
        if (we) model_write(a, wd, whb);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        n_tests++; if (ready_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_b got=%b%b exp=00", ready_b, busy_b); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        int lat;
        logic mis;
        xact(1'b1, 32'h10, 32'hDEADBEEF, SW_WORD, rd, lat, mis);
        n_tests++; if (lat !== W_A + 1) begin n_fail++; $display("FAIL wr_latency got=%0d exp=%0d", lat, W_A + 1); end
        xact(1'b0, 32'h10, 32'h0, SW_WORD, rd, lat, mis);
        n_tests++; if (lat !== W_A + 1) begin n_fail++; $display("FAIL rd_latency got=%0d exp=%0d", lat, W_A + 1); end
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd got=%h exp=deadbeef", rd); end
        xact(1'b1, 32'h13, 32'h123456AA, SW_BYTE, rd, lat, mis);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byte_wr_prewrite got=%h exp=deadbeef", rd); end
        xact(1'b0, 32'h10, 32'h0, SW_WORD, rd, lat, mis);
        n_tests++; if (rd !== 32'hAAADBEEF) begin n_fail++; $display("FAIL byte_rd got=%h exp=aaadbeef", rd); end
        xact(1'b1, 32'h12, 32'hFFFF1234, SW_HALF, rd, lat, mis);
        xact(1'b0, 32'h10, 32'h0, SW_WORD, rd, lat, mis);
        n_tests++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL half_rd got=%h exp=1234beef", rd); end
        xact(1'b0, 32'h1000_0010, 32'h0, SW_WORD, rd, lat, mis);
        n_tests++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL alias_rd got=%h exp=1234beef", rd); end
        xact(1'b1, 32'h11, 32'h00005678, SW_HALF, rd, lat, mis);
`ifdef MCCPU_MEM_ALIGN_CHK_EN
        n_tests++; if (mis !== 1'b1) begin n_fail++; $display("FAIL misalign_flag got=%b exp=1", mis); end
        xact(1'b0, 32'h10, 32'h0, SW_WORD, rd, lat, mis);
        n_tests++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL misalign_unchanged got=%h exp=1234beef", rd); end
        n_tests++; if (mis !== 1'b0) begin n_fail++; $display("FAIL misalign_clear got=%b exp=0", mis); end
`else
        xact(1'b0, 32'h10, 32'h0, SW_WORD, rd, lat, mis);
        n_tests++; if (rd !== 32'h1234BEEF && rd !== 32'h12345678) begin n_fail++; $display("FAIL half_odd_rd got=%h", rd); end
        n_tests++; if (rd !== model[4]) begin n_fail++; $display("FAIL half_odd_model got=%h exp=%h", rd, model[4]); end
`endif
    endtask

    task automatic test_busy_ignore();
        int readies;
        logic [31:0] rd;
        @(negedge clk);
        mem_req = 1'b1; MemWrite = 1'b0; adr = 32'h10; STOREwhb = SW_WORD;
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept got=%b exp=1", busy); end
        @(negedge clk);
        mem_req = 1'b1; MemWrite = 1'b1; adr = 32'h10; writedata = 32'h0; STOREwhb = SW_WORD;
        @(posedge clk);
        #1;
        mem_req = 1'b0; MemWrite = 1'b0;
        readies = 0;
        rd = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin readies++; rd = readdata; end
        end
        n_tests++; if (readies !== 1) begin n_fail++; $display("FAIL busy_ignore_readies got=%0d exp=1", readies); end
        n_tests++; if (rd !== model[4]) begin n_fail++; $display("FAIL busy_ignore_data got=%h exp=%h", rd, model[4]); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_drop got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        mem_req_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (ready_b !== ((k % 2) == 0) || busy_b !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d ready=%b busy=%b exp_ready=%b exp_busy=1", k, ready_b, busy_b, (k % 2) == 0);
            end
        end
        @(negedge clk);
        mem_req_b = 1'b0;
        @(posedge clk);
        #1;
        n_tests++; if (busy_b !== 1'b0 || ready_b !== 1'b0) begin n_fail++; $display("FAIL b2b_idle busy=%b ready=%b exp=00", busy_b, ready_b); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        logic mis;
        int readies;
        xact(1'b1, 32'h20, 32'h0BADF00D, SW_WORD, rd, lat, mis);
        @(negedge clk);
        mem_req = 1'b1; MemWrite = 1'b1; adr = 32'h20; writedata = 32'h55555555; STOREwhb = SW_WORD;
        @(posedge clk);
        #1;
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid ready=%b busy=%b exp=00", ready, busy); end
        n_tests++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_readdata got=%h exp=0", readdata); end
        @(negedge clk);
        rst = 1'b0;
        readies = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (ready) readies++;
        end
        n_tests++; if (readies !== 0) begin n_fail++; $display("FAIL rst_mid_noready got=%0d exp=0", readies); end
        xact(1'b0, 32'h20, 32'h0, SW_WORD, rd, lat, mis);
        n_tests++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL rst_mid_dropped got=%h exp=0badf00d", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd;
        int lat, idx;
        logic mis;
        logic we;
        logic [1:0] whb;
        bit chk;
        for (int i = 16; i < 24; i++) begin
            xact(1'b1, 32'(i << 2), $urandom, SW_WORD, rd, lat, mis);
            n_tests++; if (lat !== W_A + 1) begin n_fail++; $display("FAIL rnd_init_lat got=%0d exp=%0d", lat, W_A + 1); end
        end
        for (int n = 0; n < 40; n++) begin
            idx = 16 + int'($urandom_range(0, 7));
            a   = ($urandom & 32'hFFFF_F000) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            we  = 1'($urandom);
            whb = 2'($urandom);
            wd  = $urandom;
            chk = known[idx];
            exp_rd = model[idx];
            xact(we, a, wd, whb, rd, lat, mis);
            n_tests++;
            if (lat !== W_A + 1 || (chk && rd !== exp_rd)) begin
                n_fail++;
                $display("FAIL rnd%0d we=%b a=%h whb=%b lat=%0d rd=%h exp_rd=%h", n, we, a, whb, lat, rd, exp_rd);
            end
`ifdef MCCPU_MEM_ALIGN_CHK_EN
            n_tests++;
            if (mis !== is_misaligned(a, whb)) begin
                n_fail++;
                $display("FAIL rnd%0d_misalign got=%b exp=%b", n, mis, is_misaligned(a, whb));
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end
        test_reset();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
